// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the input ports, the credit return path and the
// output link of one router output arbiter.
interface noc_output_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int FLIT_W = 16,
  parameter int CNT_W  = 3
);
  logic [NUM_IN-1:0]        req_i;
  logic [NUM_IN-1:0]        tail_i;
  logic [NUM_IN*FLIT_W-1:0] flit_i;
  logic                     inc_credit_i;
  logic [NUM_IN-1:0]        pop_o;
  logic [FLIT_W-1:0]        flit_o;
  logic                     send_data;
  logic [CNT_W-1:0]         credits_o;
  logic                     busy_o;
  logic                     err_o;

  modport master (
    output req_i, tail_i, flit_i, inc_credit_i,
    input  pop_o, flit_o, send_data, credits_o, busy_o, err_o
  );

  modport slave (
    input  req_i, tail_i, flit_i, inc_credit_i,
    output pop_o, flit_o, send_data, credits_o, busy_o, err_o
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Packet-granular round-robin arbiter sharing one router output port among
// NUM_IN inputs, with downstream credit tracking and a registered output link.
module noc_output_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int FLIT_W  = 16,
  parameter int CREDITS = 5,
  parameter int CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_output_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   next_ptr;
  logic               sel_valid;
  logic               do_pop;
  logic [CNT_W-1:0]   count;
  logic [FLIT_W-1:0]  flit_q;
  logic               send;
  logic               busy;
  logic               err;

  // Scanning downwards lets the lowest offset from ptr win, giving round-robin order.
  always_comb begin
    int idx;
    idx       = 0;
    sel_valid = 1'b0;
    sel       = ptr;
    if (state == LOCKED) begin
      sel       = owner;
      sel_valid = bus.req_i[owner];
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % NUM_IN;
        if (bus.req_i[idx]) begin
          sel_valid = 1'b1;
          sel       = IDX_W'(idx);
        end
      end
    end
  end

  // Reset gates the pop so an abandoned packet loses no flit at its source.
  assign do_pop   = sel_valid && (count != '0) && !rst;
  assign next_ptr = (int'(sel) == NUM_IN - 1) ? '0 : sel + 1'b1;

  assign bus.pop_o     = do_pop ? (NUM_IN'(1) << sel) : '0;
  assign bus.flit_o    = flit_q;
  assign bus.send_data = send;
  assign bus.credits_o = count;
  assign bus.busy_o    = busy;
  assign bus.err_o     = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      count  <= CNT_W'(CREDITS);
      flit_q <= '0;
      send   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      send <= do_pop;
      if (do_pop) begin
        flit_q <= bus.flit_i[sel*FLIT_W +: FLIT_W];
      end

      // A pop and a credit return in the same cycle cancel out.
      if (do_pop && !bus.inc_credit_i) begin
        count <= count - CNT_W'(1);
      end else if (!do_pop && bus.inc_credit_i) begin
        if (count == CNT_W'(CREDITS)) begin
          err <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end

      if (do_pop) begin
        case (state)
          IDLE: begin
            if (bus.tail_i[sel]) begin
              ptr <= next_ptr;
            end else begin
              state <= LOCKED;
              owner <= sel;
              busy  <= 1'b1;
            end
          end
          LOCKED: begin
            if (bus.tail_i[sel]) begin
              state <= IDLE;
              busy  <= 1'b0;
              ptr   <= next_ptr;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: a vector table plus hand-written
// credit sequences, with a scoreboard for the registered output link.
module tb_noc_output_arbiter;
  localparam int NUM_IN  = 4;
  localparam int FLIT_W  = 16;
  localparam int CREDITS = 5;
  localparam int CNT_W   = 3;

  typedef struct {
    logic       r;
    logic [3:0] req;
    logic [3:0] tail;
    logic       inc;
    logic [3:0] pop;
    logic [2:0] cred;
    logic       busy;
    logic       err;
  } vec_t;

  typedef struct {
    logic        r;
    logic        send;
    logic [15:0] flit;
  } sb_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   step;
  logic [15:0] last_flit;
  sb_t  sb[$];
  vec_t vecs[18];

  noc_output_arbiter_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CNT_W(CNT_W)) bus ();

  noc_output_arbiter #(
    .NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CREDITS(CREDITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d actual=%0h required=%0h", name, step, act, exp);
    end
  endtask

  task automatic checkOutput(input logic [2:0] e_cred, input logic e_busy, input logic e_err);
    sb_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (e.r) last_flit = '0;
      else if (e.send) last_flit = e.flit;
      check("send_data", {31'd0, bus.send_data}, {31'd0, e.send});
      check("flit_o", {16'd0, bus.flit_o}, {16'd0, last_flit});
    end
    check("credits_o", {29'd0, bus.credits_o}, {29'd0, e_cred});
    check("busy_o", {31'd0, bus.busy_o}, {31'd0, e_busy});
    check("err_o", {31'd0, bus.err_o}, {31'd0, e_err});
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] tl,
                               input logic inc, input logic [3:0] e_pop,
                               input logic [2:0] e_cred, input logic e_busy, input logic e_err);
    sb_t e;
    logic [15:0] f;
    @(negedge clk);
    step++;
    rst              = r;
    bus.req_i        = rq;
    bus.tail_i       = tl;
    bus.inc_credit_i = inc;
    for (int i = 0; i < NUM_IN; i++) begin
      bus.flit_i[i*FLIT_W +: FLIT_W] = 16'hA000 | 16'((step << 4) + i);
    end
    #1;
    check("pop_o", {28'd0, bus.pop_o}, {28'd0, e_pop});
    f = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (e_pop[i]) f = 16'hA000 | 16'((step << 4) + i);
    end
    e.r    = r;
    e.send = (e_pop != 4'b0000) && !r;
    e.flit = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(e_cred, e_busy, e_err);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    step             = 0;
    last_flit        = '0;
    rst              = 1'b1;
    bus.req_i        = '0;
    bus.tail_i       = '0;
    bus.inc_credit_i = 1'b0;
    bus.flit_i       = '0;

    // rst, req, tail, inc, exp pop, exp credits, exp busy, exp err
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd5, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 3'd4, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd5, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 3'd5, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 3'd5, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 3'd5, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 3'd5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 3'd5, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 3'd4, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b1011, 4'b0000, 1'b0, 4'b0000, 3'd4, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 3'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1000, 3'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 3'd1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 3'd5, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001, 3'd4, 1'b0, 1'b0};

    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].r, vecs[v].req, vecs[v].tail, vecs[v].inc,
                    vecs[v].pop, vecs[v].cred, vecs[v].busy, vecs[v].err);
    end

    // Credit exhaustion, a single returned credit, then saturation error.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd5, 1'b0, 1'b0);
    for (int k = 0; k < CREDITS; k++) begin
      applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 3'(CREDITS - 1 - k), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < CREDITS; k++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'(k + 1), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd5, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd5, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 3'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd5, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
